rom_fetch_sched: RTL and testbench
==================================

ROM_FETCH_SCHED -- requirements
Module: rom_fetch_sched

Interface
REQ-001 SHALL have parameter CPU1_BASE, default 23'h000000, word base of main CPU ROM region.
REQ-002 SHALL have parameter CPU2_BASE, default 23'h004000, word base of sound CPU ROM region.
REQ-003 SHALL have parameter SP_BASE, default 23'h008000, word base of sprite ROM region.
REQ-004 SHALL have port clk_mem  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports dl_active in 1 (download in progress), dl_wr in 1 (write strobe), dl_addr in 25 (byte address), dl_data in 8 (byte data).
REQ-007 SHALL have ports cpu1_addr in 15 (word address) and cpu1_q out 16 (cached word).
REQ-008 SHALL have ports cpu2_addr in 13 (word address), cpu2_vma in 1 (address-valid strobe) and cpu2_q out 16.
REQ-009 SHALL have ports sp_addr in 15 (32-bit word address) and sp_q out 32.
REQ-010 SHALL have ports mem_req out 1 (toggle), mem_ack in 1 (toggle), mem_we out 1, mem_a out 23, mem_ds out 2, mem_d out 16 and mem_q in 16.
REQ-011 SHALL have ports busy out 1 (transfer outstanding) and dl_overrun out 1 (sticky flag).

Function
REQ-012 SHALL keep at most one memory transfer outstanding: issue by toggling mem_req; complete when mem_ack == mem_req.
REQ-013 SHALL drive mem_we, mem_a, mem_ds and mem_d stable from the issuing edge until completion.
REQ-014 SHALL use FSM states IDLE, WAIT, SP_HI_WAIT.
- IDLE: on grant -> toggle mem_req -> WAIT.
- WAIT: on completion -> capture -> IDLE, or, for sprite low half, issue high half -> SP_HI_WAIT.
- SP_HI_WAIT: on completion -> IDLE.
REQ-015 SHALL detect a download write on the rising edge of dl_wr while dl_active=1 and latch dl_addr/dl_data into a one-entry pending slot.
REQ-016 SHALL issue a write as: mem_we=1, mem_a=dl_addr[23:1], mem_ds={dl_addr[0],~dl_addr[0]}, mem_d={dl_data,dl_data}.
REQ-017 SHALL, on a dl_wr edge while the slot is full and a write is in flight, drop the new byte and set dl_overrun until reset.
REQ-018 SHALL grant in IDLE by fixed priority: pending write > sprite > cpu1 > cpu2.
REQ-019 SHALL not grant reads while dl_active=1.
REQ-020 SHALL raise a cpu1 read request when cpu1_addr differs from the last fetched cpu1 address or the cpu1 tag is invalid; mem_a = CPU1_BASE + cpu1_addr.
REQ-021 SHALL register cpu2_addr only in cycles with cpu2_vma=1, and request on mismatch with that registered address; mem_a = CPU2_BASE + addr.
REQ-022 SHALL fetch a sprite as two reads, low half at SP_BASE + {sp_addr,1'b0} and high half at SP_BASE + {sp_addr,1'b1}; sp_q[15:0] = low word, sp_q[31:16] = high word.
REQ-023 SHALL update sp_q (both halves) only when the high-half read completes.
REQ-024 SHALL, for a sprite address change during a fetch, complete the current pair and then refetch.
REQ-025 SHALL update cpu1_q or cpu2_q one clock after the completing edge.
REQ-026 SHALL tag each cache with the address used at issue; an address change during a fetch yields a new request after completion.
REQ-027 SHALL invalidate all three tags on the falling edge of dl_active.
REQ-028 SHALL assert busy whenever state != IDLE.
REQ-029 SHALL give a mem_ack toggle arriving in IDLE no effect.

Reset
REQ-030 SHALL, on reset_n=0, immediately force:
- state=IDLE, mem_req=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0
- cpu1_q=0, cpu2_q=0, sp_q=0, busy=0, dl_overrun=0
- pending slot empty, all tags invalid
REQ-031 SHALL abandon any in-flight transfer on reset; the memory controller SHALL be reset with its ack=0 in the same domain.

Structure
REQ-032 SHALL place the state enum and the three base constants in shared package rom_sched_pkg.
REQ-033 SHALL implement the pending write slot and overrun logic in one sub-module, dl_write_slot; the rest is flat.

Verification
REQ-034 SHALL cover a download write: dl_active=1, dl_wr pulse, dl_addr=25'h00003, dl_data=8'hA5 -> mem_we=1, mem_a=23'h000001, mem_ds=2'b10, mem_d=16'hA5A5, one mem_req toggle.
REQ-035 SHALL cover a cpu1 fetch: cpu1_addr=15'h0123, ack returned 3 cycles later with mem_q=16'hBEEF -> mem_a=23'h000123, cpu1_q=16'hBEEF; holding the same address issues no further request.
REQ-036 SHALL cover a sprite fetch: sp_addr=15'h0002, mem_q=16'h1111 then 16'h2222 -> mem_a 23'h008004 then 23'h008005, sp_q=32'h22221111 after the second ack only.
REQ-037 SHALL cover priority: sprite, cpu1 and cpu2 requests raised in the same cycle -> grant order sprite (2 reads), cpu1, cpu2; busy high throughout.
REQ-038 SHALL cover overrun: three dl_wr edges while ack is withheld -> third byte dropped, dl_overrun=1; after ack, only two writes are issued.
REQ-039 SHALL cover reset mid-transfer: reset_n=0 in WAIT -> all outputs 0 immediately; after release with cpu1_addr unchanged -> one new fetch.

Source files
------------

// File: rtl/rom_sched_pkg.sv
// Shared types and default ROM region bases for the ROM fetch scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_sched_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT       = 2'd1,
        SP_HI_WAIT = 2'd2
    } state_t;

    // What the outstanding transfer is for; selects where read data lands.
    typedef enum logic [1:0] {
        K_WR   = 2'd0,
        K_SP   = 2'd1,
        K_CPU1 = 2'd2,
        K_CPU2 = 2'd3
    } kind_t;

    localparam logic [22:0] DEF_CPU1_BASE = 23'h000000;
    localparam logic [22:0] DEF_CPU2_BASE = 23'h004000;
    localparam logic [22:0] DEF_SP_BASE   = 23'h008000;

    // Byte-lane enables for a byte write into a 16-bit word: odd byte -> upper lane.
    function automatic logic [1:0] byte_lanes(input logic a0);
        return {a0, ~a0};
    endfunction

endpackage

// File: rtl/dl_write_slot.sv
// One-entry holding slot for download bytes, with sticky overrun flag.
// Latency: byte visible on pend_* one clk_mem after the dl_wr rising edge.
// Backpressure: none upstream; a byte arriving while the slot is full and not being drained is dropped and flagged.
//
// Ports: dl_active/dl_wr/dl_addr/dl_data - download strobe interface;
//        take - scheduler consumes the slot this cycle;
//        pend_vld/pend_addr/pend_data - slot contents; dl_overrun - sticky until reset.
module dl_write_slot (
    input  logic        clk_mem,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        take,
    output logic        pend_vld,
    output logic [23:0] pend_addr,
    output logic [7:0]  pend_data,
    output logic        dl_overrun
);

    logic dl_wr_d;
    logic wr_edge;
    logic unused_addr_msb;

    // The sdram word space only spans 24 byte-address bits.
    assign unused_addr_msb = dl_addr[24];

    assign wr_edge = dl_active & dl_wr & ~dl_wr_d;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_d    <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            dl_overrun <= 1'b0;
        end else begin
            dl_wr_d <= dl_wr;
            // A slot being drained this cycle can accept a new byte in the same cycle.
            if (wr_edge && (!pend_vld || take)) begin
                pend_vld  <= 1'b1;
                pend_addr <= dl_addr[23:0];
                pend_data <= dl_data;
            end else if (take) begin
                pend_vld <= 1'b0;
            end
            if (wr_edge && pend_vld && !take) begin
                dl_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_fetch_sched.sv
// Arbitrates download writes and three cached ROM readers onto one toggle-handshake memory port.
// Latency: grant one clk_mem after a request appears in IDLE; cpu1_q/cpu2_q update one clk after ack seen, sp_q on ack of the high half.
// Backpressure: one transfer outstanding; new requests wait in IDLE, download bytes beyond the one-entry slot are dropped.
//
// Ports: clk_mem/reset_n; dl_* download writes; cpu1_addr->cpu1_q, cpu2_addr/cpu2_vma->cpu2_q,
//        sp_addr->sp_q (32-bit, two reads); mem_* toggle req/ack memory port; busy, dl_overrun status.
module rom_fetch_sched
    import rom_sched_pkg::*;
#(
    parameter logic [22:0] CPU1_BASE = DEF_CPU1_BASE,
    parameter logic [22:0] CPU2_BASE = DEF_CPU2_BASE,
    parameter logic [22:0] SP_BASE   = DEF_SP_BASE
) (
    input  logic        clk_mem,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic [14:0] cpu1_addr,
    output logic [15:0] cpu1_q,
    input  logic [12:0] cpu2_addr,
    input  logic        cpu2_vma,
    output logic [15:0] cpu2_q,
    input  logic [14:0] sp_addr,
    output logic [31:0] sp_q,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q,
    output logic        busy,
    output logic        dl_overrun
);

    state_t      state, state_nxt;
    kind_t       cur_kind, iss_kind;

    logic        pend_vld;
    logic [23:0] pend_addr;
    logic [7:0]  pend_data;
    logic        take;

    logic        issue;
    logic        iss_we;
    logic [22:0] iss_a;
    logic [1:0]  iss_ds;
    logic [15:0] iss_d;
    logic        cap_ld, sp_lo_ld, sp_ld;

    logic [14:0] cpu1_tag;
    logic        cpu1_tag_vld;
    logic [12:0] cpu2_addr_r;
    logic [12:0] cpu2_tag;
    logic        cpu2_tag_vld;
    logic [14:0] sp_tag;
    logic        sp_tag_vld;
    logic [15:0] sp_lo;
    logic        cap_vld, cap_cpu1;
    logic [15:0] cap_dat;
    logic        dl_active_d;

    logic        done;
    logic        dl_fall;
    logic        cpu1_req, cpu2_req, sp_req;

    dl_write_slot u_slot (
        .clk_mem    (clk_mem),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .take       (take),
        .pend_vld   (pend_vld),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .dl_overrun (dl_overrun)
    );

    assign done     = (mem_ack == mem_req);
    assign dl_fall  = dl_active_d & ~dl_active;
    assign busy     = (state != IDLE);

    assign cpu1_req = !cpu1_tag_vld || (cpu1_addr != cpu1_tag);
    assign cpu2_req = !cpu2_tag_vld || (cpu2_addr_r != cpu2_tag);
    assign sp_req   = !sp_tag_vld   || (sp_addr != sp_tag);

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        take      = 1'b0;
        iss_kind  = cur_kind;
        iss_we    = 1'b0;
        iss_a     = '0;
        iss_ds    = 2'b11;
        iss_d     = '0;
        cap_ld    = 1'b0;
        sp_lo_ld  = 1'b0;
        sp_ld     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    issue     = 1'b1;
                    take      = 1'b1;
                    iss_kind  = K_WR;
                    iss_we    = 1'b1;
                    iss_a     = pend_addr[23:1];
                    iss_ds    = byte_lanes(pend_addr[0]);
                    iss_d     = {pend_data, pend_data};
                    state_nxt = WAIT;
                end else if (!dl_active && sp_req) begin
                    issue     = 1'b1;
                    iss_kind  = K_SP;
                    iss_a     = SP_BASE + 23'({sp_addr, 1'b0});
                    state_nxt = WAIT;
                end else if (!dl_active && cpu1_req) begin
                    issue     = 1'b1;
                    iss_kind  = K_CPU1;
                    iss_a     = CPU1_BASE + 23'(cpu1_addr);
                    state_nxt = WAIT;
                end else if (!dl_active && cpu2_req) begin
                    issue     = 1'b1;
                    iss_kind  = K_CPU2;
                    iss_a     = CPU2_BASE + 23'(cpu2_addr_r);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    if (cur_kind == K_SP) begin
                        // High half uses the pair's tagged address, not the live sp_addr.
                        sp_lo_ld  = 1'b1;
                        issue     = 1'b1;
                        iss_kind  = K_SP;
                        iss_a     = SP_BASE + 23'({sp_tag, 1'b1});
                        state_nxt = SP_HI_WAIT;
                    end else begin
                        cap_ld    = (cur_kind == K_CPU1) || (cur_kind == K_CPU2);
                        state_nxt = IDLE;
                    end
                end
            end
            SP_HI_WAIT: begin
                if (done) begin
                    sp_ld     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_a        <= '0;
            mem_ds       <= '0;
            mem_d        <= '0;
            cur_kind     <= K_WR;
            cpu1_tag     <= '0;
            cpu1_tag_vld <= 1'b0;
            cpu2_addr_r  <= '0;
            cpu2_tag     <= '0;
            cpu2_tag_vld <= 1'b0;
            sp_tag       <= '0;
            sp_tag_vld   <= 1'b0;
            sp_lo        <= '0;
            sp_q         <= '0;
            cap_vld      <= 1'b0;
            cap_cpu1     <= 1'b0;
            cap_dat      <= '0;
            cpu1_q       <= '0;
            cpu2_q       <= '0;
            dl_active_d  <= 1'b0;
        end else begin
            dl_active_d <= dl_active;
            if (cpu2_vma) begin
                cpu2_addr_r <= cpu2_addr;
            end
            // End of download: ROM contents changed under the caches.
            if (dl_fall) begin
                cpu1_tag_vld <= 1'b0;
                cpu2_tag_vld <= 1'b0;
                sp_tag_vld   <= 1'b0;
            end
            if (issue) begin
                mem_req  <= ~mem_req;
                mem_we   <= iss_we;
                mem_a    <= iss_a;
                mem_ds   <= iss_ds;
                mem_d    <= iss_d;
                cur_kind <= iss_kind;
                // A read granted in the same cycle as the download ends already sees new ROM, so its tag stands.
                if (state == IDLE) begin
                    case (iss_kind)
                        K_SP: begin
                            sp_tag     <= sp_addr;
                            sp_tag_vld <= 1'b1;
                        end
                        K_CPU1: begin
                            cpu1_tag     <= cpu1_addr;
                            cpu1_tag_vld <= 1'b1;
                        end
                        K_CPU2: begin
                            cpu2_tag     <= cpu2_addr_r;
                            cpu2_tag_vld <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (sp_lo_ld) begin
                sp_lo <= mem_q;
            end
            if (sp_ld) begin
                sp_q <= {mem_q, sp_lo};
            end
            cap_vld <= cap_ld;
            if (cap_ld) begin
                cap_dat  <= mem_q;
                cap_cpu1 <= (cur_kind == K_CPU1);
            end
            if (cap_vld) begin
                if (cap_cpu1) begin
                    cpu1_q <= cap_dat;
                end else begin
                    cpu2_q <= cap_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_sched.sv
// Self-checking bench for rom_fetch_sched with a toggle-handshake memory model.
// Latency: memory acks ack_delay cycles after seeing a new request.
// Backpressure: ack_hold stalls the memory model's ack.
module tb_rom_fetch_sched;

    typedef struct packed {
        logic        we;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } txn_t;

    logic        clk_mem = 1'b0;
    logic        reset_n;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [14:0] cpu1_addr;
    logic [15:0] cpu1_q;
    logic [12:0] cpu2_addr;
    logic        cpu2_vma;
    logic [15:0] cpu2_q;
    logic [14:0] sp_addr;
    logic [31:0] sp_q;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        mem_we;
    logic [22:0] mem_a;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [15:0] mem_q = 16'h0000;
    logic        busy, dl_overrun;

    int          n_cmp = 0;
    int          n_fail = 0;
    txn_t        exp_q[$];
    logic [15:0] rsp_q[$];
    int          n_issued = 0;
    int          stable_err = 0;
    int          busy_err = 0;
    bit          ack_hold = 1'b0;
    int          ack_delay = 3;
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic        last_req = 1'b0;
    txn_t        snap, cur_t, e_t;

    always #5 clk_mem = ~clk_mem;

    rom_fetch_sched dut (
        .clk_mem    (clk_mem),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .cpu1_addr  (cpu1_addr),
        .cpu1_q     (cpu1_q),
        .cpu2_addr  (cpu2_addr),
        .cpu2_vma   (cpu2_vma),
        .cpu2_q     (cpu2_q),
        .sp_addr    (sp_addr),
        .sp_q       (sp_q),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_ds     (mem_ds),
        .mem_d      (mem_d),
        .mem_q      (mem_q),
        .busy       (busy),
        .dl_overrun (dl_overrun)
    );

    // Memory controller model plus scoreboard: every new request is popped against exp_q.
    always @(posedge clk_mem) begin
        #1;
        if (!reset_n) begin
            mem_ack  = 1'b0;
            m_pend   = 1'b0;
            last_req = 1'b0;
        end else begin
            cur_t = {mem_we, mem_a, mem_ds, mem_d};
            if (mem_req != mem_ack && !busy) busy_err++;
            if (mem_req != last_req) begin
                last_req = mem_req;
                snap     = cur_t;
                m_pend   = 1'b1;
                m_cnt    = ack_delay;
                n_issued++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL txn_unexpected: got we=%0b a=%h ds=%b d=%h, required none", cur_t.we, cur_t.a, cur_t.ds, cur_t.d);
                end else begin
                    e_t = exp_q.pop_front();
                    if (cur_t !== e_t) begin
                        n_fail++;
                        $display("FAIL txn: got we=%0b a=%h ds=%b d=%h, required we=%0b a=%h ds=%b d=%h",
                                 cur_t.we, cur_t.a, cur_t.ds, cur_t.d, e_t.we, e_t.a, e_t.ds, e_t.d);
                    end
                end
            end else if (m_pend) begin
                if (cur_t !== snap) stable_err++;
                if (!ack_hold) begin
                    if (m_cnt > 1) begin
                        m_cnt--;
                    end else begin
                        if (!mem_we) mem_q = (rsp_q.size() != 0) ? rsp_q.pop_front() : 16'hDEAD;
                        mem_ack = mem_req;
                        m_pend  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_quiet(input int budget, output bit ok);
        int q;
        q  = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_mem); #2;
            if (!busy && !m_pend && exp_q.size() == 0) q++; else q = 0;
            if (q >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_issued(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_mem); #2;
            if (n_issued >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_mem);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        @(negedge clk_mem);
        dl_wr   = 1'b0;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        dl_active = 1'b1;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        cpu1_addr = '0;
        cpu2_addr = '0;
        cpu2_vma  = 1'b0;
        sp_addr   = '0;
        repeat (3) @(posedge clk_mem);
        #2;
        n_cmp++;
        if ({mem_req, mem_we, mem_a, mem_ds, mem_d, busy, dl_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_port: got req=%b we=%b a=%h ds=%b d=%h busy=%b ovr=%b, required all 0",
                     mem_req, mem_we, mem_a, mem_ds, mem_d, busy, dl_overrun);
        end
        n_cmp++;
        if ({cpu1_q, cpu2_q, sp_q} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_q: got cpu1=%h cpu2=%h sp=%h, required 0", cpu1_q, cpu2_q, sp_q);
        end
        @(negedge clk_mem);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_mem);
        #2;
        n_cmp++;
        if (n_issued !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_reads_in_dl: got issued=%0d busy=%b, required 0 0", n_issued, busy);
        end
    endtask

    task automatic test_download;
        int base;
        bit ok;
        base = n_issued;
        exp_q.push_back({1'b1, 23'h000001, 2'b10, 16'hA5A5});
        pulse_wr(25'h00003, 8'hA5);
        wait_quiet(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL download_timeout: got no quiet, required quiet"); end
        n_cmp++;
        if (n_issued - base !== 1) begin
            n_fail++;
            $display("FAIL download_count: got %0d toggles, required 1", n_issued - base);
        end
        n_cmp++;
        if (dl_overrun !== 1'b0) begin n_fail++; $display("FAIL download_ovr: got %b, required 0", dl_overrun); end
    endtask

    task automatic test_overrun;
        int base;
        bit ok;
        base     = n_issued;
        ack_hold = 1'b1;
        exp_q.push_back({1'b1, 23'h000008, 2'b01, 16'h1111});
        exp_q.push_back({1'b1, 23'h000008, 2'b10, 16'h2222});
        pulse_wr(25'h00010, 8'h11);
        pulse_wr(25'h00011, 8'h22);
        pulse_wr(25'h00012, 8'h33);
        repeat (2) @(posedge clk_mem);
        #2;
        n_cmp++;
        if (dl_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b, required 1", dl_overrun); end
        n_cmp++;
        if (n_issued - base !== 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_held: got issued=%0d busy=%b, required 1 1", n_issued - base, busy);
        end
        ack_hold = 1'b0;
        wait_quiet(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL overrun_timeout: got no quiet, required quiet"); end
        n_cmp++;
        if (n_issued - base !== 2) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d writes, required 2", n_issued - base);
        end
        n_cmp++;
        if (dl_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", dl_overrun); end
    endtask

    task automatic test_priority;
        int base;
        bit ok;
        base = n_issued;
        @(negedge clk_mem);
        cpu1_addr = 15'h0123;
        sp_addr   = 15'h0002;
        cpu2_addr = 13'h0045;
        cpu2_vma  = 1'b1;
        @(negedge clk_mem);
        cpu2_vma  = 1'b0;
        cpu2_addr = 13'h1FFF;
        exp_q.push_back({1'b0, 23'h008004, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h008005, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h000123, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h004045, 2'b11, 16'h0000});
        rsp_q.push_back(16'h1111);
        rsp_q.push_back(16'h2222);
        rsp_q.push_back(16'hBEEF);
        rsp_q.push_back(16'hCAFE);
        @(negedge clk_mem);
        dl_active = 1'b0;
        wait_issued(base + 2, 100, ok);
        n_cmp++;
        if (!ok || sp_q !== 32'h0) begin
            n_fail++;
            $display("FAIL sprite_low_only: got reached=%0b sp_q=%h, required 1 00000000", ok, sp_q);
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL sprite_busy: got %b, required 1", busy); end
        wait_quiet(200, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL priority_timeout: got no quiet, required quiet"); end
        n_cmp++;
        if (sp_q !== 32'h22221111) begin n_fail++; $display("FAIL sprite_q: got %h, required 22221111", sp_q); end
        n_cmp++;
        if (cpu1_q !== 16'hBEEF) begin n_fail++; $display("FAIL cpu1_q: got %h, required beef", cpu1_q); end
        n_cmp++;
        if (cpu2_q !== 16'hCAFE) begin n_fail++; $display("FAIL cpu2_q: got %h, required cafe", cpu2_q); end
        base = n_issued;
        repeat (20) @(posedge clk_mem);
        #2;
        n_cmp++;
        if (n_issued !== base) begin
            n_fail++;
            $display("FAIL cpu1_hold_no_refetch: got %0d extra requests, required 0", n_issued - base);
        end
    endtask

    task automatic test_addr_change;
        int base;
        bit ok;
        base = n_issued;
        exp_q.push_back({1'b0, 23'h000124, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h000125, 2'b11, 16'h0000});
        rsp_q.push_back(16'h1234);
        rsp_q.push_back(16'h5678);
        @(negedge clk_mem);
        cpu1_addr = 15'h0124;
        wait_issued(base + 1, 50, ok);
        @(negedge clk_mem);
        cpu1_addr = 15'h0125;
        wait_quiet(200, ok);
        n_cmp++;
        if (!ok || cpu1_q !== 16'h5678 || n_issued - base !== 2) begin
            n_fail++;
            $display("FAIL cpu1_change: got quiet=%0b q=%h n=%0d, required 1 5678 2", ok, cpu1_q, n_issued - base);
        end

        base = n_issued;
        @(negedge clk_mem);
        cpu2_addr = 13'h00AA;
        repeat (10) @(posedge clk_mem);
        #2;
        n_cmp++;
        if (n_issued !== base) begin
            n_fail++;
            $display("FAIL cpu2_no_vma: got %0d requests, required 0", n_issued - base);
        end
        exp_q.push_back({1'b0, 23'h0040AA, 2'b11, 16'h0000});
        rsp_q.push_back(16'h0BAD);
        @(negedge clk_mem);
        cpu2_vma = 1'b1;
        @(negedge clk_mem);
        cpu2_vma = 1'b0;
        wait_quiet(100, ok);
        n_cmp++;
        if (!ok || cpu2_q !== 16'h0BAD) begin
            n_fail++;
            $display("FAIL cpu2_vma: got quiet=%0b q=%h, required 1 0bad", ok, cpu2_q);
        end

        base = n_issued;
        exp_q.push_back({1'b0, 23'h008006, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h008007, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h008008, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h008009, 2'b11, 16'h0000});
        rsp_q.push_back(16'h3333);
        rsp_q.push_back(16'h4444);
        rsp_q.push_back(16'h5555);
        rsp_q.push_back(16'h6666);
        @(negedge clk_mem);
        sp_addr = 15'h0003;
        wait_issued(base + 1, 50, ok);
        @(negedge clk_mem);
        sp_addr = 15'h0004;
        wait_quiet(200, ok);
        n_cmp++;
        if (!ok || sp_q !== 32'h66665555 || n_issued - base !== 4) begin
            n_fail++;
            $display("FAIL sprite_change: got quiet=%0b sp_q=%h n=%0d, required 1 66665555 4", ok, sp_q, n_issued - base);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        base     = n_issued;
        ack_hold = 1'b1;
        exp_q.push_back({1'b0, 23'h000300, 2'b11, 16'h0000});
        @(negedge clk_mem);
        cpu1_addr = 15'h0300;
        wait_issued(base + 1, 50, ok);
        n_cmp++;
        if (!ok || busy !== 1'b1 || mem_req === mem_ack) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got issued=%0b busy=%b, required 1 1", ok, busy);
        end
        @(negedge clk_mem);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, mem_a, mem_ds, mem_d, busy, dl_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_port: got req=%b we=%b a=%h ds=%b d=%h busy=%b ovr=%b, required all 0",
                     mem_req, mem_we, mem_a, mem_ds, mem_d, busy, dl_overrun);
        end
        n_cmp++;
        if ({cpu1_q, cpu2_q, sp_q} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_q: got cpu1=%h cpu2=%h sp=%h, required 0", cpu1_q, cpu2_q, sp_q);
        end
        ack_hold = 1'b0;
        repeat (2) @(posedge clk_mem);
        base = n_issued;
        exp_q.push_back({1'b0, 23'h008008, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h008009, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h000300, 2'b11, 16'h0000});
        exp_q.push_back({1'b0, 23'h0040AA, 2'b11, 16'h0000});
        rsp_q.push_back(16'h0A0A);
        rsp_q.push_back(16'h0B0B);
        rsp_q.push_back(16'h0C0C);
        rsp_q.push_back(16'h0D0D);
        @(negedge clk_mem);
        cpu2_vma = 1'b1;
        reset_n  = 1'b1;
        wait_quiet(200, ok);
        cpu2_vma = 1'b0;
        n_cmp++;
        if (!ok || n_issued - base !== 4) begin
            n_fail++;
            $display("FAIL reset_mid_refetch: got quiet=%0b n=%0d, required 1 4", ok, n_issued - base);
        end
        n_cmp++;
        if (cpu1_q !== 16'h0C0C || sp_q !== 32'h0B0B0A0A || cpu2_q !== 16'h0D0D) begin
            n_fail++;
            $display("FAIL reset_mid_data: got cpu1=%h sp=%h cpu2=%h, required 0c0c 0b0b0a0a 0d0d", cpu1_q, sp_q, cpu2_q);
        end
    endtask

    task automatic test_stability;
        n_cmp++;
        if (stable_err !== 0) begin n_fail++; $display("FAIL mem_port_stable: got %0d changes, required 0", stable_err); end
        n_cmp++;
        if (busy_err !== 0) begin n_fail++; $display("FAIL busy_outstanding: got %0d low cycles, required 0", busy_err); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_download;
        test_overrun;
        test_priority;
        test_addr_change;
        test_reset_mid;
        test_stability;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
